wb_regfile_unit: RTL

Writeback stage and architectural register file of the VeSPA CPU. It consumes the MEM/WB pipeline-register outputs, selects the writeback value and writes the register file. It holds off the pipeline while load data from data memory is outstanding. It also serves the two decode-stage read ports.

---
 rtl/wb_regfile_unit_pkg.sv | 22 ++
 rtl/wb_regfile_array.sv | 57 +++++
 rtl/wb_regfile_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_unit_pkg.sv
// ----------------------------------------------------------------------------
// wb_regfile_unit_pkg
// Shared constants for the VeSPA writeback stage:
//   - RF_SEL_* : 2-bit writeback-source encodings carried on i_RfDataInSel
//   - wb_state_t : writeback FSM states (WB_IDLE / WB_WAIT)
//   - MEM_TIMEOUT_DEFAULT : default load-data wait budget in cycles
// ----------------------------------------------------------------------------
package wb_regfile_unit_pkg;

    localparam logic [1:0] RF_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_SEL_MEM = 2'd1;
    localparam logic [1:0] RF_SEL_IMM = 2'd2;
    localparam logic [1:0] RF_SEL_PC  = 2'd3;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/wb_regfile_array.sv
// ----------------------------------------------------------------------------
// wb_regfile_array
// Architectural register storage: one synchronous write port, two
// asynchronous read ports. Every register (r0 included) is writable.
// Synchronous active-high reset clears all entries.
//
// Optional build macro WB_BYPASS_EN: when defined, a read whose address
// matches a write committing this cycle returns the write data
// (write-through). When undefined, reads return the stored value only.
//
// Ports:
//   i_Clk, i_Rst          clock (rising edge), synchronous active-high reset
//   i_WrEn                write strobe
//   i_WrAddr, i_WrData    write address / data
//   i_RdAddr1, i_RdAddr2  read addresses
//   o_RdData1, o_RdData2  read data
// ----------------------------------------------------------------------------
module wb_regfile_array #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_WrEn,
    input  logic [ADDR_W-1:0] i_WrAddr,
    input  logic [DATA_W-1:0] i_WrData,
    input  logic [ADDR_W-1:0] i_RdAddr1,
    input  logic [ADDR_W-1:0] i_RdAddr2,
    output logic [DATA_W-1:0] o_RdData1,
    output logic [DATA_W-1:0] o_RdData2
);

    logic [DATA_W-1:0] r_Mem [NUM_REGS];

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_Mem[i] <= '0;
            end
        end else if (i_WrEn) begin
            r_Mem[i_WrAddr] <= i_WrData;
        end
    end

`ifdef WB_BYPASS_EN
    // A write held off by reset never commits, so it must not be forwarded.
    logic w_Commit;
    assign w_Commit  = i_WrEn && !i_Rst;
    assign o_RdData1 = (w_Commit && (i_RdAddr1 == i_WrAddr)) ? i_WrData : r_Mem[i_RdAddr1];
    assign o_RdData2 = (w_Commit && (i_RdAddr2 == i_WrAddr)) ? i_WrData : r_Mem[i_RdAddr2];
`else
    assign o_RdData1 = r_Mem[i_RdAddr1];
    assign o_RdData2 = r_Mem[i_RdAddr2];
`endif

endmodule

// File: rtl/wb_regfile_unit.sv
// ----------------------------------------------------------------------------
// wb_regfile_unit
// Writeback stage + architectural register file of the VeSPA CPU.
// Selects the writeback value from the MEM/WB pipeline register, writes the
// register file, and holds the pipeline while load data is outstanding.
// A load that receives no data within MEM_TIMEOUT wait cycles is abandoned
// and raises the sticky o_MemErr flag.
//
// Build macro: WB_BYPASS_EN (write-through read ports, see wb_regfile_array).
//
// Handshake: i_MemRdValid is a one-sided valid qualifying i_MemRdData; it is
// only consumed while a load is being written back and is ignored otherwise.
// o_StallReq is the backpressure toward the pipeline: while it is high the
// MEM/WB inputs are held stable; the cycle it drops the current instruction
// retires (data written, or load abandoned on timeout).
//
// Ports:
//   i_Clk, i_Rst                 clock, synchronous active-high reset
//   i_ProgramCounter, i_AluOut,
//   i_Imm22                      writeback candidates from MEM/WB
//   i_IrRst                      destination register
//   i_WrEnRf, i_RfDataInSel      write enable, source select (RF_SEL_*)
//   i_MemRdData, i_MemRdValid    load data from data memory
//   i_RdAddr1/2, o_RdData1/2     decode-stage read ports
//   o_StallReq                   pipeline hold request
//   o_MemErr                     sticky load-timeout flag
//   o_DbgState                   current FSM state (wb_state_t encoding)
// ----------------------------------------------------------------------------
module wb_regfile_unit
    import wb_regfile_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] i_ProgramCounter,
    input  logic [ADDR_W-1:0] i_IrRst,
    input  logic [DATA_W-1:0] i_AluOut,
    input  logic [DATA_W-1:0] i_Imm22,
    input  logic              i_WrEnRf,
    input  logic [1:0]        i_RfDataInSel,
    input  logic [DATA_W-1:0] i_MemRdData,
    input  logic              i_MemRdValid,
    input  logic [ADDR_W-1:0] i_RdAddr1,
    input  logic [ADDR_W-1:0] i_RdAddr2,
    output logic [DATA_W-1:0] o_RdData1,
    output logic [DATA_W-1:0] o_RdData2,
    output logic              o_StallReq,
    output logic              o_MemErr,
    output logic              o_DbgState
);

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    wb_state_t         r_State;
    wb_state_t         w_NextState;
    logic [CNT_W-1:0]  r_WaitCnt;
    logic [CNT_W-1:0]  w_NextCnt;
    logic [ADDR_W-1:0] r_CapAddr;
    logic [ADDR_W-1:0] w_NextCapAddr;
    logic              r_MemErr;
    logic              w_SetErr;

    logic              w_IsLoad;
    logic [DATA_W-1:0] w_SelData;
    logic              w_WrEn;
    logic [ADDR_W-1:0] w_WrAddr;
    logic [DATA_W-1:0] w_WrData;

    assign w_IsLoad = i_WrEnRf && (i_RfDataInSel == RF_SEL_MEM);

    always_comb begin
        case (i_RfDataInSel)
            RF_SEL_ALU: w_SelData = i_AluOut;
            RF_SEL_MEM: w_SelData = i_MemRdData;
            RF_SEL_IMM: w_SelData = i_Imm22;
            default:    w_SelData = i_ProgramCounter;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State   <= WB_IDLE;
            r_WaitCnt <= '0;
            r_CapAddr <= '0;
            r_MemErr  <= 1'b0;
        end else begin
            r_State   <= w_NextState;
            r_WaitCnt <= w_NextCnt;
            r_CapAddr <= w_NextCapAddr;
            if (w_SetErr) begin
                r_MemErr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_NextState   = r_State;
        w_NextCnt     = r_WaitCnt;
        w_NextCapAddr = r_CapAddr;
        w_SetErr      = 1'b0;
        w_WrEn        = 1'b0;
        w_WrAddr      = i_IrRst;
        w_WrData      = w_SelData;
        o_StallReq    = 1'b0;
        case (r_State)
            WB_IDLE: begin
                if (w_IsLoad) begin
                    if (i_MemRdValid) begin
                        w_WrEn = 1'b1;
                    end else begin
                        o_StallReq    = 1'b1;
                        w_NextState   = WB_WAIT;
                        w_NextCnt     = '0;
                        w_NextCapAddr = i_IrRst;
                    end
                end else if (i_WrEnRf) begin
                    w_WrEn = 1'b1;
                end
            end
            WB_WAIT: begin
                // The address captured on entry is authoritative here.
                w_WrAddr = r_CapAddr;
                w_WrData = i_MemRdData;
                if (i_MemRdValid) begin
                    w_WrEn      = 1'b1;
                    w_NextState = WB_IDLE;
                end else if (r_WaitCnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    // Give up: release the pipeline without writing.
                    w_SetErr    = 1'b1;
                    w_NextState = WB_IDLE;
                    w_NextCnt   = '0;
                end else begin
                    o_StallReq = 1'b1;
                    w_NextCnt  = r_WaitCnt + CNT_W'(1);
                end
            end
            default: begin
                w_NextState = WB_IDLE;
            end
        endcase
    end

    assign o_MemErr   = r_MemErr;
    assign o_DbgState = r_State;

    wb_regfile_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_array (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_WrEn    (w_WrEn),
        .i_WrAddr  (w_WrAddr),
        .i_WrData  (w_WrData),
        .i_RdAddr1 (i_RdAddr1),
        .i_RdAddr2 (i_RdAddr2),
        .o_RdData1 (o_RdData1),
        .o_RdData2 (o_RdData2)
    );

endmodule
